// File: rtl/fpu_op_sequencer_pkg.sv
// rtl/fpu_op_sequencer_pkg.sv - shared types and constants for the fpu op sequencer
package fpu_op_sequencer_pkg;

   typedef logic [15:0] fp16_t;
   typedef enum logic [1:0] {FPU_ADD, FPU_SUB, FPU_MUL, FPU_DIV} fpuOp_t;
   typedef logic [3:0] condCode_t;

   typedef struct packed {
      logic       nv;
      logic       dz;
      logic [2:0] opFlags;
   } statusFlag_t;

   typedef struct packed {
      logic lt;
      logic eq;
      logic gt;
   } fpuComp_t;

   localparam fp16_t FP16_NAN = 16'h7E00;

   typedef enum logic [2:0] {IDLE, EXEC, START, WAIT, RESP} seqState_t;

   // MUL/DIV are the multi-cycle fpu ops that need a start pulse and a done level
   function automatic logic isLongOp(fpuOp_t op);
      return (op == FPU_MUL) || (op == FPU_DIV);
   endfunction

endpackage

// File: rtl/fpu_op_sequencer_if.sv
// rtl/fpu_op_sequencer_if.sv - request/response handshake bundle between requester and sequencer
interface fpu_op_sequencer_if;
   import fpu_op_sequencer_pkg::*;

   logic        reqValid;
   logic        reqReady;
   fpuOp_t      reqOp;
   fp16_t       reqIn1;
   fp16_t       reqIn2;
   logic        rspValid;
   logic        rspReady;
   fp16_t       rspOut;
   condCode_t   rspCond;
   statusFlag_t rspFlags;
   fpuComp_t    rspComps;
   logic        rspTimeout;

   modport master (
      output reqValid, reqOp, reqIn1, reqIn2, rspReady,
      input  reqReady, rspValid, rspOut, rspCond, rspFlags, rspComps, rspTimeout
   );

   modport slave (
      input  reqValid, reqOp, reqIn1, reqIn2, rspReady,
      output reqReady, rspValid, rspOut, rspCond, rspFlags, rspComps, rspTimeout
   );

endinterface

// File: rtl/fpu_seq_watchdog.sv
// rtl/fpu_seq_watchdog.sv - counts enabled cycles and flags expiry on the TIMEOUT_CYCLES-th one
module fpu_seq_watchdog #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CW-1:0] count;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

   // count holds (enabled cycles so far - 1), so expiry lands on the last allowed cycle
   assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fpu_op_sequencer.sv
// rtl/fpu_op_sequencer.sv - single-requester controller driving an fpu and holding its response
module fpu_op_sequencer
   import fpu_op_sequencer_pkg::*;
#(
   parameter type FP_T           = fp16_t,
   parameter int  TIMEOUT_CYCLES = 64,
   parameter int  CNT_W          = 16
) (
   input  logic              clock,
   input  logic              reset,
   fpu_op_sequencer_if.slave host,
   input  logic              flagsClr,
   output statusFlag_t       accFlags,
   output logic [CNT_W-1:0]  opCount,
   output FP_T               fpuIn1,
   output FP_T               fpuIn2,
   output fpuOp_t            fpuOp,
   output logic              fpuStart,
   input  FP_T               fpuOut,
   input  logic              mulDone,
   input  logic              divDone,
   input  condCode_t         condCodes,
   input  statusFlag_t       statusFlags,
   input  fpuComp_t          comps
);

   seqState_t   state, stateNext;
   logic        accept, capture, expired, doneSel;
   fp16_t       capOut;
   condCode_t   capCond;
   statusFlag_t capFlags, keepFlags;
   logic        capTimeout;

   fp16_t       rspOutQ;
   condCode_t   rspCondQ;
   statusFlag_t rspFlagsQ;
   fpuComp_t    rspCompsQ;
   logic        rspTimeoutQ;

   fpu_seq_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) watchdog (
      .clock   (clock),
      .reset   (reset),
      .clear   (state != WAIT),
      .enable  (state == WAIT),
      .expired (expired)
   );

   assign accept   = (state == IDLE) && host.reqValid;
   assign doneSel  = (fpuOp == FPU_MUL) ? mulDone : divDone;

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext  = state;
      capture    = 1'b0;
      capTimeout = 1'b0;
      capOut     = fp16_t'(fpuOut);
      capCond    = condCodes;
      capFlags   = statusFlags;
      case (state)
         IDLE:  if (host.reqValid) stateNext = isLongOp(host.reqOp) ? START : EXEC;
         EXEC: begin
            capture   = 1'b1;
            stateNext = RESP;
         end
         START: stateNext = WAIT;
         WAIT: begin
            // a done arriving on the final watchdog cycle still wins over the timeout
            if (doneSel) begin
               capture   = 1'b1;
               stateNext = RESP;
            end else if (expired) begin
               capture    = 1'b1;
               capTimeout = 1'b1;
               capOut     = FP16_NAN;
               capCond    = '0;
               capFlags   = '0;
               stateNext  = RESP;
            end
         end
         RESP:  if (host.rspReady) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   assign keepFlags = flagsClr ? statusFlag_t'('0) : accFlags;

   always_ff @(posedge clock) begin
      if (reset) begin
         fpuIn1      <= '0;
         fpuIn2      <= '0;
         fpuOp       <= FPU_ADD;
         rspOutQ     <= '0;
         rspCondQ    <= '0;
         rspFlagsQ   <= '0;
         rspCompsQ   <= '0;
         rspTimeoutQ <= 1'b0;
         accFlags    <= '0;
         opCount     <= '0;
      end else begin
         if (accept) begin
            fpuIn1 <= FP_T'(host.reqIn1);
            fpuIn2 <= FP_T'(host.reqIn2);
            fpuOp  <= host.reqOp;
         end
         if (capture) begin
            rspOutQ     <= capOut;
            rspCondQ    <= capCond;
            rspFlagsQ   <= capFlags;
            rspCompsQ   <= comps;
            rspTimeoutQ <= capTimeout;
            accFlags    <= keepFlags | capFlags;
            opCount     <= opCount + CNT_W'(1);
         end else if (flagsClr) begin
            accFlags <= '0;
         end
      end
   end

   assign host.reqReady   = (state == IDLE);
   assign host.rspValid   = (state == RESP);
   assign host.rspOut     = rspOutQ;
   assign host.rspCond    = rspCondQ;
   assign host.rspFlags   = rspFlagsQ;
   assign host.rspComps   = rspCompsQ;
   assign host.rspTimeout = rspTimeoutQ;
   assign fpuStart        = (state == START);

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb/tb_fpu_op_sequencer.sv - self-checking bench for fpu_op_sequencer with a stand-in fpu
module tb_fpu_op_sequencer;
   import fpu_op_sequencer_pkg::*;

   localparam int TO = 64;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        flagsClr;
   statusFlag_t accFlags;
   logic [15:0] opCount;
   fp16_t       fpuIn1, fpuIn2, fpuOut;
   fpuOp_t      fpuOp;
   logic        fpuStart, mulDone, divDone;
   condCode_t   condCodes;
   statusFlag_t statusFlags;
   fpuComp_t    comps;

   always #5 clock = ~clock;

   fpu_op_sequencer_if bus ();

   fpu_op_sequencer #(.FP_T(fp16_t), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
      .clock       (clock),
      .reset       (reset),
      .host        (bus.slave),
      .flagsClr    (flagsClr),
      .accFlags    (accFlags),
      .opCount     (opCount),
      .fpuIn1      (fpuIn1),
      .fpuIn2      (fpuIn2),
      .fpuOp       (fpuOp),
      .fpuStart    (fpuStart),
      .fpuOut      (fpuOut),
      .mulDone     (mulDone),
      .divDone     (divDone),
      .condCodes   (condCodes),
      .statusFlags (statusFlags),
      .comps       (comps)
   );

   typedef struct {
      fpuOp_t      op;
      fp16_t       a, b, res;
      logic [4:0]  fl;
      logic [3:0]  cc;
      logic [2:0]  cp;
      int          doneAt;
      int          hold;
      logic        clr;
      fp16_t       expOut;
      logic [4:0]  expFlags;
      logic [3:0]  expCc;
      logic        expTo;
      int          expLat;
      logic [4:0]  expAcc;
      logic [15:0] expCnt;
   } vec_t;

   int          nCmp = 0;
   int          nBad = 0;
   logic [15:0] mCnt;
   logic [4:0]  mAcc;
   vec_t        tbl[8];

   function void check(string name, logic [63:0] act, logic [63:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endfunction

   task automatic checkResetState(string tag);
      check({tag, ".reqReady"}, bus.reqReady, 1'b1);
      check({tag, ".rspValid"}, bus.rspValid, 1'b0);
      check({tag, ".fpuStart"}, fpuStart, 1'b0);
      check({tag, ".rspAll"}, {bus.rspOut, bus.rspCond, bus.rspFlags, bus.rspComps, bus.rspTimeout}, 64'd0);
      check({tag, ".accFlags"}, accFlags, 5'd0);
      check({tag, ".opCount"}, opCount, 16'd0);
      check({tag, ".opRegs"}, {fpuIn1, fpuIn2, fpuOp}, 64'd0);
   endtask

   task automatic runOp(vec_t v, string tag);
      int   k;
      logic seen;
      logic lng;
      lng = (v.op == FPU_MUL) || (v.op == FPU_DIV);
      k = 0;
      while (!bus.reqReady && k < 200) begin
         @(negedge clock);
         k++;
      end
      check({tag, ".idleReady"}, bus.reqReady, 1'b1);
      bus.reqValid = 1'b1;
      bus.reqOp    = v.op;
      bus.reqIn1   = v.a;
      bus.reqIn2   = v.b;
      fpuOut       = v.res;
      statusFlags  = v.fl;
      condCodes    = v.cc;
      comps        = v.cp;
      flagsClr     = v.clr;
      mulDone      = 1'b0;
      divDone      = 1'b0;
      @(negedge clock);
      bus.reqValid = 1'b0;
      bus.reqIn1   = 16'($urandom);
      bus.reqIn2   = 16'($urandom);
      bus.reqOp    = fpuOp_t'($urandom_range(0, 3));
      k    = 1;
      seen = 1'b0;
      while (k < 200 && !seen) begin
         if (bus.rspValid) begin
            seen = 1'b1;
         end else begin
            check({tag, ".start"}, fpuStart, lng && (k == 1));
            check({tag, ".ops"}, {fpuIn1, fpuIn2, fpuOp}, {v.a, v.b, v.op});
            check({tag, ".busyReady"}, bus.reqReady, 1'b0);
            if (v.op == FPU_MUL) begin
               mulDone = ((v.doneAt != 0) && (k == 1 + v.doneAt)) || ((k == 1) && ($urandom_range(0, 1) == 1));
               divDone = 1'($urandom_range(0, 1));
            end else if (v.op == FPU_DIV) begin
               divDone = ((v.doneAt != 0) && (k == 1 + v.doneAt)) || ((k == 1) && ($urandom_range(0, 1) == 1));
               mulDone = 1'($urandom_range(0, 1));
            end else begin
               mulDone = 1'($urandom_range(0, 1));
               divDone = 1'($urandom_range(0, 1));
            end
            @(negedge clock);
            k++;
         end
      end
      mulDone  = 1'b0;
      divDone  = 1'b0;
      flagsClr = 1'b0;
      check({tag, ".latency"}, k, v.expLat);
      check({tag, ".rspOut"}, bus.rspOut, v.expOut);
      check({tag, ".rspFlags"}, bus.rspFlags, v.expFlags);
      check({tag, ".rspCond"}, bus.rspCond, v.expCc);
      check({tag, ".rspComps"}, bus.rspComps, v.cp);
      check({tag, ".rspTimeout"}, bus.rspTimeout, v.expTo);
      check({tag, ".accFlags"}, accFlags, v.expAcc);
      check({tag, ".opCount"}, opCount, v.expCnt);
      // the fpu moves on; the held response must not follow it
      fpuOut      = 16'($urandom);
      statusFlags = 5'($urandom);
      condCodes   = 4'($urandom);
      comps       = 3'($urandom);
      for (int i = 0; i < v.hold; i++) begin
         @(negedge clock);
         check({tag, ".holdValid"}, {bus.rspValid, bus.reqReady}, 2'b10);
         check({tag, ".holdRsp"}, {bus.rspOut, bus.rspFlags, bus.rspCond, bus.rspTimeout, opCount},
               {v.expOut, v.expFlags, v.expCc, v.expTo, v.expCnt});
         check({tag, ".holdOps"}, {fpuIn1, fpuIn2, fpuOp}, {v.a, v.b, v.op});
      end
      bus.rspReady = 1'b1;
      @(negedge clock);
      bus.rspReady = 1'b0;
      check({tag, ".released"}, {bus.rspValid, bus.reqReady}, 2'b01);
   endtask

   initial begin
      vec_t v;
      logic lng;
      bus.reqValid = 1'b0;
      bus.reqOp    = FPU_ADD;
      bus.reqIn1   = '0;
      bus.reqIn2   = '0;
      bus.rspReady = 1'b0;
      flagsClr     = 1'b0;
      fpuOut       = '0;
      mulDone      = 1'b0;
      divDone      = 1'b0;
      condCodes    = '0;
      statusFlags  = '0;
      comps        = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      checkResetState("reset");

      tbl[0] = '{FPU_ADD, 16'h3C00, 16'h4000, 16'h4200, 5'b00000, 4'h0, 3'b001, 0,  0,  1'b0, 16'h4200, 5'b00000, 4'h0, 1'b0, 2,  5'b00000, 16'd1};
      tbl[1] = '{FPU_MUL, 16'h4000, 16'h4200, 16'h4600, 5'b00000, 4'h0, 3'b001, 5,  0,  1'b0, 16'h4600, 5'b00000, 4'h0, 1'b0, 7,  5'b00000, 16'd2};
      tbl[2] = '{FPU_DIV, 16'h3C00, 16'h0000, 16'h7C00, 5'b01000, 4'h2, 3'b001, 3,  2,  1'b0, 16'h7C00, 5'b01000, 4'h2, 1'b0, 5,  5'b01000, 16'd3};
      tbl[3] = '{FPU_SUB, 16'h4000, 16'h3C00, 16'h3C00, 5'b00001, 4'h0, 3'b001, 0,  0,  1'b1, 16'h3C00, 5'b00001, 4'h0, 1'b0, 2,  5'b00001, 16'd4};
      tbl[4] = '{FPU_MUL, 16'h4200, 16'h4200, 16'h4880, 5'b00100, 4'h1, 3'b010, 1,  10, 1'b0, 16'h4880, 5'b00100, 4'h1, 1'b0, 3,  5'b00101, 16'd5};
      tbl[5] = '{FPU_DIV, 16'h4000, 16'h3C00, 16'h4000, 5'b10000, 4'h4, 3'b100, 0,  1,  1'b0, 16'h7E00, 5'b00000, 4'h0, 1'b1, 66, 5'b00101, 16'd6};
      tbl[6] = '{FPU_ADD, 16'h7C00, 16'hFC00, 16'h7E00, 5'b10000, 4'h8, 3'b000, 0,  0,  1'b0, 16'h7E00, 5'b10000, 4'h8, 1'b0, 2,  5'b10101, 16'd7};
      tbl[7] = '{FPU_MUL, 16'h3C00, 16'h3C00, 16'h1234, 5'b00010, 4'h0, 3'b010, 64, 0,  1'b0, 16'h1234, 5'b00010, 4'h0, 1'b0, 66, 5'b10111, 16'd8};
      for (int i = 0; i < 8; i++) begin
         runOp(tbl[i], $sformatf("vec%0d", i));
         mCnt = tbl[i].expCnt;
         mAcc = tbl[i].expAcc;
      end

      for (int i = 0; i < 30; i++) begin
         v.op     = fpuOp_t'($urandom_range(0, 3));
         v.a      = 16'($urandom);
         v.b      = 16'($urandom);
         v.res    = 16'($urandom);
         v.fl     = 5'($urandom);
         v.cc     = 4'($urandom);
         v.cp     = 3'($urandom);
         v.doneAt = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
         v.hold   = int'($urandom_range(0, 3));
         v.clr    = ($urandom_range(0, 3) == 0);
         lng      = (v.op == FPU_MUL) || (v.op == FPU_DIV);
         v.expTo    = lng && (v.doneAt == 0);
         v.expLat   = !lng ? 2 : (v.expTo ? 2 + TO : 2 + v.doneAt);
         v.expOut   = v.expTo ? 16'h7E00 : v.res;
         v.expFlags = v.expTo ? 5'd0 : v.fl;
         v.expCc    = v.expTo ? 4'd0 : v.cc;
         mAcc       = (v.clr ? 5'd0 : mAcc) | v.expFlags;
         mCnt       = mCnt + 16'd1;
         v.expAcc   = mAcc;
         v.expCnt   = mCnt;
         runOp(v, $sformatf("rnd%0d", i));
      end

      // reset while waiting on divDone: the op vanishes without a response
      bus.reqValid = 1'b1;
      bus.reqOp    = FPU_DIV;
      bus.reqIn1   = 16'h4400;
      bus.reqIn2   = 16'h4000;
      @(negedge clock);
      bus.reqValid = 1'b0;
      repeat (4) @(negedge clock);
      check("midReset.waiting", {bus.rspValid, bus.reqReady}, 2'b00);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checkResetState("midReset");
      divDone = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("midReset.noRsp", bus.rspValid, 1'b0);
      end
      divDone = 1'b0;
      mCnt = 16'd0;
      mAcc = 5'd0;

      // opCount wrap from all-ones
      force dut.opCount = 16'hFFFF;
      @(negedge clock);
      release dut.opCount;
      mCnt = 16'hFFFF;
      v.op     = FPU_ADD;
      v.a      = 16'h3C00;
      v.b      = 16'h3C00;
      v.res    = 16'h4000;
      v.fl     = 5'b00001;
      v.cc     = 4'h2;
      v.cp     = 3'b010;
      v.doneAt = 0;
      v.hold   = 0;
      v.clr    = 1'b0;
      v.expTo    = 1'b0;
      v.expLat   = 2;
      v.expOut   = 16'h4000;
      v.expFlags = 5'b00001;
      v.expCc    = 4'h2;
      mAcc       = mAcc | v.expFlags;
      mCnt       = mCnt + 16'd1;
      v.expAcc   = mAcc;
      v.expCnt   = mCnt;
      runOp(v, "wrap");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
